// File: rtl/serdes_pkg.sv
// Shared types and sizing helpers for the framed serial receiver.
package serdes_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    // Bits needed to hold the values 0..max_value, never less than one.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/serdes_rx_shift.sv
// Serial-to-parallel window with selectable insert direction and sync-word compare.
module serdes_rx_shift
    import serdes_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter bit                    MSB_FIRST      = 1'b1,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD      = DATA_WIDTH'(SYNC_WORD_DEFAULT),
    parameter bit                    TAP_POST_SHIFT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic                  bit_in,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  sync_match
);

    logic [DATA_WIDTH-1:0] window;
    logic [DATA_WIDTH-1:0] window_next;

    always_comb begin
        if (MSB_FIRST) window_next = {window[DATA_WIDTH-2:0], bit_in};
        else           window_next = {bit_in, window[DATA_WIDTH-1:1]};
    end

    // The compare looks at the window including the bit arriving this cycle.
    assign sync_match = (window_next == SYNC_WORD);
    assign word       = TAP_POST_SHIFT ? window_next : window;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           window <= '0;
        else if (shift_en) window <= window_next;
    end

endmodule

// File: rtl/serdes_frame_aligner_rx.sv
// Sync-word hunter, frame flywheel and single-entry output stage for a framed bitstream.
// Define SERDES_FRAME_ALIGNER_PARITY_EN for an even-parity bit after every payload word.
module serdes_frame_aligner_rx
    import serdes_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter bit                    MSB_FIRST    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD    = DATA_WIDTH'(SYNC_WORD_DEFAULT),
    parameter int                    FRAME_WORDS  = 4,
    parameter int                    LOCK_COUNT   = 3,
    parameter int                    UNLOCK_COUNT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  bit_valid,
    input  logic                  serial_in,
    input  logic                  resync,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  locked,
    output logic                  overflow
`ifdef SERDES_FRAME_ALIGNER_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

`ifdef SERDES_FRAME_ALIGNER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam int SLOT_BITS   = DATA_WIDTH + PAR_BITS;
    localparam int BIT_CNT_W   = cnt_width(SLOT_BITS - 1);
    localparam int WORD_CNT_W  = cnt_width(FRAME_WORDS);
    localparam int MATCH_CNT_W = cnt_width(LOCK_COUNT);
    localparam int MISS_CNT_W  = cnt_width(UNLOCK_COUNT);

    localparam logic [BIT_CNT_W-1:0]   SYNC_LAST     = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0]   PAYLOAD_LAST  = BIT_CNT_W'(SLOT_BITS - 1);
    localparam logic [WORD_CNT_W-1:0]  LAST_WORD     = WORD_CNT_W'(FRAME_WORDS);
    localparam logic [WORD_CNT_W-1:0]  FIRST_WORD    = WORD_CNT_W'(1);
    localparam logic [MATCH_CNT_W-1:0] LOCK_TARGET   = MATCH_CNT_W'(LOCK_COUNT);
    localparam logic [MISS_CNT_W-1:0]  UNLOCK_TARGET = MISS_CNT_W'(UNLOCK_COUNT);

    state_t                  state;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [WORD_CNT_W-1:0]   word_cnt;
    logic [MATCH_CNT_W-1:0]  match_cnt;
    logic [MISS_CNT_W-1:0]   miss_cnt;

    logic                  consume;
    logic                  in_sync_slot;
    logic                  slot_end;
    logic                  word_done;
    logic                  sync_match;
    logic [DATA_WIDTH-1:0] word;

    assign consume      = enable && bit_valid && !resync;
    assign in_sync_slot = (word_cnt == '0);
    assign slot_end     = (bit_cnt == (in_sync_slot ? SYNC_LAST : PAYLOAD_LAST));
    assign word_done    = consume && (state == LOCKED) && !in_sync_slot && slot_end;

    // With parity the slot ends on the parity bit, so the word is the window before that shift.
    serdes_rx_shift #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MSB_FIRST      (MSB_FIRST),
        .SYNC_WORD      (SYNC_WORD),
        .TAP_POST_SHIFT (PAR_BITS == 0)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (consume),
        .bit_in     (serial_in),
        .word       (word),
        .sync_match (sync_match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            locked    <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else if (resync) begin
            state     <= HUNT;
            locked    <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else if (consume) begin
            if (state == HUNT) begin
                if (sync_match) begin
                    bit_cnt   <= '0;
                    word_cnt  <= FIRST_WORD;
                    match_cnt <= MATCH_CNT_W'(1);
                    miss_cnt  <= '0;
                    if (LOCK_COUNT == 1) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end else begin
                        state  <= VERIFY;
                    end
                end
            end else if (slot_end) begin
                bit_cnt  <= '0;
                word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
                if (in_sync_slot) begin
                    // Losing the frame: later assignments here override the flywheel advance above.
                    if (state == VERIFY) begin
                        if (!sync_match) begin
                            state     <= HUNT;
                            bit_cnt   <= '0;
                            word_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt + 1'b1 == LOCK_TARGET) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end
                    end else begin
                        if (sync_match) begin
                            miss_cnt <= '0;
                        end else if (miss_cnt + 1'b1 == UNLOCK_TARGET) begin
                            state     <= HUNT;
                            locked    <= 1'b0;
                            bit_cnt   <= '0;
                            word_cnt  <= '0;
                            match_cnt <= '0;
                            miss_cnt  <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Single-entry output stage: a load into an unaccepted full register is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_sof      <= 1'b0;
            overflow   <= 1'b0;
`ifdef SERDES_FRAME_ALIGNER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overflow <= 1'b0;
            if (word_done) begin
                if (!m_valid || m_ready) begin
                    m_data  <= word;
                    m_valid <= 1'b1;
                    m_sof   <= (word_cnt == FIRST_WORD);
`ifdef SERDES_FRAME_ALIGNER_PARITY_EN
                    parity_err <= ^{word, serial_in};
`endif
                end else begin
                    overflow <= 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serdes_frame_aligner_rx.sv
// Scoreboard bench: stimulus pushes expected payload words, monitors pop them on each handshake.
module tb_serdes_frame_aligner_rx;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       resync;
    logic       m_ready;
    logic       bit_valid, serial_in;
    logic       bit_valid1, serial_in1;
    logic [7:0] m_data, m_data1;
    logic       m_valid, m_valid1, m_sof, m_sof1;
    logic       locked, locked1, overflow, overflow1;
`ifdef SERDES_FRAME_ALIGNER_PARITY_EN
    logic       parity_err, parity_err1;
`endif

    exp_t       q0[$];
    exp_t       q1[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] payload [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk = ~clk;

    serdes_frame_aligner_rx dut0 (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bit_valid  (bit_valid),
        .serial_in  (serial_in),
        .resync     (resync),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_sof      (m_sof),
        .locked     (locked),
        .overflow   (overflow)
`ifdef SERDES_FRAME_ALIGNER_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    serdes_frame_aligner_rx #(.MSB_FIRST(1'b0)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bit_valid  (bit_valid1),
        .serial_in  (serial_in1),
        .resync     (resync),
        .m_data     (m_data1),
        .m_valid    (m_valid1),
        .m_ready    (m_ready),
        .m_sof      (m_sof1),
        .locked     (locked1),
        .overflow   (overflow1)
`ifdef SERDES_FRAME_ALIGNER_PARITY_EN
        ,
        .parity_err (parity_err1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && m_valid && m_ready) begin
            if (q0.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut0_unexpected_word: got %02h sof %0b expected none", m_data, m_sof);
            end else begin
                e = q0.pop_front();
                check("dut0_data", 32'(m_data), 32'(e.data));
                check("dut0_sof", 32'(m_sof), 32'(e.sof));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && m_valid1 && m_ready) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut1_unexpected_word: got %02h sof %0b expected none", m_data1, m_sof1);
            end else begin
                e = q1.pop_front();
                check("dut1_data", 32'(m_data1), 32'(e.data));
                check("dut1_sof", 32'(m_sof1), 32'(e.sof));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push0(input logic [7:0] v, input logic s);
        exp_t e;
        e.data = v;
        e.sof  = s;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [7:0] v, input logic s);
        exp_t e;
        e.data = v;
        e.sof  = s;
        q1.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        serial_in = b;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [7:0] sync, input logic deliver, input logic exp_locked,
                              input string name);
        send_byte(sync);
        check(name, 32'(locked), 32'(exp_locked));
        for (int i = 0; i < 4; i++) begin
            if (deliver) push0(payload[i], i == 0);
            send_byte(payload[i]);
        end
    endtask

    task automatic send_bit1(input logic b);
        bit_valid1 = 1'b1;
        serial_in1 = b;
        @(posedge clk);
        #1;
        bit_valid1 = 1'b0;
        idle(2);
    endtask

    task automatic send_byte1(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit1(v[i]);
    endtask

    task automatic send_frame1(input logic deliver, input logic exp_locked, input string name);
        send_byte1(8'hA5);
        check(name, 32'(locked1), 32'(exp_locked));
        for (int i = 0; i < 4; i++) begin
            if (deliver) push1(payload[i], i == 0);
            send_byte1(payload[i]);
        end
    endtask

    task automatic apply_reset();
        m_ready = 1'b1;
        idle(4);
        check("queue_drained_before_reset", 32'(q0.size() + q1.size()), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        rst        = 1'b1;
        enable     = 1'b1;
        resync     = 1'b0;
        m_ready    = 1'b1;
        bit_valid  = 1'b0;
        serial_in  = 1'b0;
        bit_valid1 = 1'b0;
        serial_in1 = 1'b0;
        #12;
        check("reset_m_data", 32'(m_data), 32'd0);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_m_sof", 32'(m_sof), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Clean stream: lock after the third sync, payload flows from then on.
        repeat (16) send_bit(1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, "t1_locked_f1");
        send_frame(8'hA5, 1'b0, 1'b0, "t1_locked_f2");
        send_frame(8'hA5, 1'b1, 1'b1, "t1_locked_f3");
        send_byte(8'hA5);
        check("t1_locked_f4", 32'(locked), 32'd1);
        push0(8'h11, 1'b1);
        w = 8'h11;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        check("t1_valid_before_last_bit", 32'(m_valid), 32'd0);
        send_bit(w[0]);
        check("t1_valid_after_last_bit", 32'(m_valid), 32'd1);
        check("t1_first_data", 32'(m_data), 32'h11);
        check("t1_first_sof", 32'(m_sof), 32'd1);
        for (int i = 1; i < 4; i++) begin
            push0(payload[i], 1'b0);
            send_byte(payload[i]);
        end

        // False sync inside payload, then true alignment.
        apply_reset();
        repeat (8) send_bit(1'b0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_frame(8'hA5, 1'b0, 1'b0, "t2_locked_f1");
        send_frame(8'hA5, 1'b0, 1'b0, "t2_locked_f2");
        send_frame(8'hA5, 1'b0, 1'b0, "t2_locked_f3");
        send_frame(8'hA5, 1'b1, 1'b1, "t2_locked_f4");

        // Loss of lock: one miss tolerated, two consecutive misses drop lock.
        send_frame(8'hA4, 1'b1, 1'b1, "t3_one_miss");
        send_frame(8'hA5, 1'b1, 1'b1, "t3_recovered");
        send_frame(8'hA4, 1'b1, 1'b1, "t3_miss_a");
        send_frame(8'hA4, 1'b0, 1'b0, "t3_miss_b");
        check("t3_no_output_after_unlock", 32'(m_valid), 32'd0);

        // Backpressure: 11 held, 22 dropped with an overflow pulse, then 33.
        apply_reset();
        repeat (8) send_bit(1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, "t4_locked_f1");
        send_frame(8'hA5, 1'b0, 1'b0, "t4_locked_f2");
        send_frame(8'hA5, 1'b1, 1'b1, "t4_locked_f3");
        send_byte(8'hA5);
        m_ready = 1'b0;
        push0(8'h11, 1'b1);
        send_byte(8'h11);
        check("t4_first_loaded", 32'(m_valid), 32'd1);
        check("t4_no_overflow_yet", 32'(overflow), 32'd0);
        send_byte(8'h22);
        check("t4_overflow_pulse", 32'(overflow), 32'd1);
        check("t4_data_held", 32'(m_data), 32'h11);
        check("t4_sof_held", 32'(m_sof), 32'd1);
        m_ready = 1'b1;
        idle(1);
        check("t4_overflow_one_cycle", 32'(overflow), 32'd0);
        check("t4_accepted", 32'(m_valid), 32'd0);
        push0(8'h33, 1'b0);
        send_byte(8'h33);
        push0(8'h44, 1'b0);
        send_byte(8'h44);

        // LSB-first instance with a bit every third cycle.
        apply_reset();
        repeat (8) send_bit1(1'b0);
        send_frame1(1'b0, 1'b0, "t5_locked_f1");
        send_frame1(1'b0, 1'b0, "t5_locked_f2");
        send_frame1(1'b1, 1'b1, "t5_locked_f3");
        send_frame1(1'b1, 1'b1, "t5_locked_f4");

        // Asynchronous reset mid-word clears a pending word and the lock.
        apply_reset();
        repeat (8) send_bit(1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, "t6_locked_f1");
        send_frame(8'hA5, 1'b0, 1'b0, "t6_locked_f2");
        send_frame(8'hA5, 1'b1, 1'b1, "t6_locked_f3");
        send_byte(8'hA5);
        m_ready = 1'b0;
        send_byte(8'h11);
        check("t6_pending_before_rst", 32'(m_valid), 32'd1);
        w = 8'h22;
        for (int i = 7; i >= 3; i--) send_bit(w[i]);
        rst = 1'b1;
        #1;
        check("t6_rst_m_valid", 32'(m_valid), 32'd0);
        check("t6_rst_m_data", 32'(m_data), 32'd0);
        check("t6_rst_m_sof", 32'(m_sof), 32'd0);
        check("t6_rst_locked", 32'(locked), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (8) send_bit(1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, "t6_relock_f1");
        send_frame(8'hA5, 1'b0, 1'b0, "t6_relock_f2");
        send_frame(8'hA5, 1'b1, 1'b1, "t6_relock_f3");

        // resync while locked keeps the pending word and drops lock.
        send_byte(8'hA5);
        m_ready = 1'b0;
        push0(8'h11, 1'b1);
        send_byte(8'h11);
        w = 8'h22;
        for (int i = 7; i >= 5; i--) send_bit(w[i]);
        resync = 1'b1;
        send_bit(w[4]);
        resync = 1'b0;
        check("t6_resync_unlocked", 32'(locked), 32'd0);
        check("t6_resync_pending_valid", 32'(m_valid), 32'd1);
        check("t6_resync_pending_data", 32'(m_data), 32'h11);
        m_ready = 1'b1;
        idle(2);
        check("t6_pending_accepted", 32'(m_valid), 32'd0);

        idle(4);
        check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serdes_frame_aligner_rx.md
Name: serdes_frame_aligner_rx

Overview:
- Receive-side companion to the team's framed serializer.
- Consumes a continuous serial bitstream and hunts for a periodic sync word, declaring lock after repeated matches.
- Once locked, deserializes payload words and presents them on a valid/ready stream with start-of-frame marking.
- Sits between the serial pin/CDR sampling stage and the parallel datapath.

Parameters:
- DATA_WIDTH, 8, width of sync word and payload words (>=4).
- MSB_FIRST, 1, 1 = first received bit is word MSB; 0 = first bit is LSB.
- SYNC_WORD, 8'hA5 (DATA_WIDTH bits), frame delimiter pattern.
- FRAME_WORDS, 4, payload words following each sync word (>=1).
- LOCK_COUNT, 3, consecutive sync matches, including the first detection, required to enter LOCKED (>=1).
- UNLOCK_COUNT, 2, consecutive sync misses in LOCKED that force a return to HUNT (>=1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  0 = hold all state; bit_valid ignored
- bit_valid  input  1  qualifies serial_in for one bit this cycle
- serial_in  input  1  serial data bit
- resync  input  1  synchronous pulse: force HUNT, clear counters
- m_data  output  DATA_WIDTH  payload word
- m_valid  output  1  m_data valid
- m_ready  input  1  downstream accepts when m_valid && m_ready
- m_sof  output  1  qualifies m_data as the first payload word of a frame
- locked  output  1  high in LOCKED state
- overflow  output  1  one-cycle pulse when a completed word is dropped

Behaviour:
- Reset values: m_data=0, m_valid=0, m_sof=0, locked=0, overflow=0; state=HUNT; shift register, bit counter, word counter and match/miss counters all 0.
- A bit is consumed only on cycles with enable && bit_valid.
- Shift rule:
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
- The sync compare always uses the post-shift value.
- Frame length is (FRAME_WORDS+1)*DATA_WIDTH bits. The bit counter counts 0..DATA_WIDTH-1 and wraps; the word counter counts 0..FRAME_WORDS and wraps (0 = sync slot).
- HUNT:
  - Compares the sliding window after every consumed bit.
  - On match: counters zeroed, word counter set to 1 (payload next), match count=1.
  - If LOCK_COUNT==1, go straight to LOCKED; otherwise go to VERIFY.
- VERIFY:
  - Payload bits are skipped (not output).
  - At each sync-slot boundary, a match increments the match count, and reaching LOCK_COUNT enters LOCKED.
  - A mismatch returns to HUNT with match count=0.
- LOCKED:
  - locked=1.
  - At each sync-slot boundary, a match clears the miss count; a mismatch increments it, and reaching UNLOCK_COUNT goes to HUNT.
  - While the miss count is below UNLOCK_COUNT, payload keeps flowing using the flywheel timing.
- Output:
  - Only in LOCKED, on the cycle a payload word's last bit is consumed, the word is loaded into the output register on the next edge: m_valid rises one cycle after the final bit.
  - m_sof=1 iff the word is the first after the sync slot.
- Output register semantics:
  - The output register is single-entry.
  - If it is full and not accepted on the load cycle, the new word is dropped, old data is held and overflow pulses.
  - If m_ready is high on that cycle, accept and load happen together (no drop).
- m_valid/m_data are held stable until accepted. Leaving LOCKED does not clear a pending word.
- resync takes priority over bit consumption in the same cycle; the pending output word is kept.
- The asynchronous rst clears everything immediately, mid-word or mid-frame; the partial word is discarded.
- enable=0 freezes all counters and state. A pending output word can still be accepted.

Optional Feature:
- Macro: SERDES_FRAME_ALIGNER_PARITY_EN.
- Defined:
  - Each payload word is followed by one even-parity bit (payload slot = DATA_WIDTH+1 bits; the sync slot has no parity).
  - Added output port parity_err (1 bit) travels with m_data and is set when the received parity mismatches. The word is still delivered.
- Undefined: no parity bit and no parity_err port; frame timing is as above.

Decomposition:
- Package serdes_pkg:
  - state enum (HUNT, VERIFY, LOCKED);
  - default SYNC_WORD constant;
  - counter-width helper constants derived via $clog2.
- One sub-module: serdes_rx_shift.
  - Parameterized shift register with MSB_FIRST insert direction.
  - Registered window output and combinational sync_match.

Test Plan:
- Clean stream, defaults, bit_valid every cycle: idle 0s, then 3 frames of A5,11,22,33,44 → locked rises after the third sync. Frames 4 onwards deliver 11(m_sof=1),22,33,44, with m_valid 1 cycle after the last bit.
- False sync: payload contains A5 at a non-frame offset before a true frame → HUNT may hit it, VERIFY mismatches, returns to HUNT, and eventually locks on true alignment with no words output before lock.
- Loss of lock: while locked, corrupt one sync word (A4) → stays locked and payload continues. Corrupt two consecutive syncs → locked drops after the second, and output stops.
- Backpressure: locked, m_ready=0 for 2 word times → first word 11 held, second word 22 dropped with one overflow pulse. Raise m_ready → 11 accepted, next output 33.
- MSB_FIRST=0, bit_valid every 3rd cycle → same byte values recovered LSB-first, and gaps do not shift alignment.
- Reset/resync mid-word: assert rst at bit 5 of a payload word → all outputs 0 immediately and relock needs 3 syncs. Pulse resync while locked → locked=0 next cycle and a pending word is retained.
